// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg: shared sequencer state encoding and width helpers for clock/reset logic
package clk_rst_pkg;
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, RELEASE, RUN, FAULT} pll_seq_state_t;
  localparam int LOL_W = 8;
  function automatic int bits(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/lock_filter.sv
// lock_filter: synchronizes one asynchronous PLL lock and debounces it into a stable flag
module lock_filter
  import clk_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic lock,
  input  logic hold,
  output logic synced,
  output logic stable
);
  localparam int CW = bits(LOCK_FILTER);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  assign synced = sync[SYNC_STAGES-1];
  assign stable = cnt == CW'(LOCK_FILTER);
  // shift the asynchronous lock through the synchronizer chain
  always_ff @(posedge clk)
    if (rst) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], lock};
  // count consecutive synced-high cycles outside PLL reset, saturating at the filter length
  always_ff @(posedge clk)
    if (rst || !synced || hold) cnt <= '0;
    else if (!stable) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses PLL resets, waits for filtered lock, releases domain resets in order
module pll_reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter int N_PLL          = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_FILTER    = 1024,
  parameter int LOCK_TIMEOUT   = 250000,
  parameter int PLL_RST_CYCLES = 16,
  parameter int RELEASE_GAP    = 8,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [N_PLL-1:0]               i_lock,
  output logic [N_PLL-1:0]               o_pll_rst,
  output logic [N_PLL-1:0]               o_dom_rst,
  output logic                           o_ready,
  output logic                           o_fault,
  output logic [bits(MAX_RETRIES)-1:0]   o_retry_cnt,
  output logic [LOL_W-1:0]               o_lol_cnt
);
  localparam int RW = bits(MAX_RETRIES);
  localparam int TW = bits(max3(LOCK_TIMEOUT, PLL_RST_CYCLES, RELEASE_GAP));
  localparam int KW = bits(N_PLL - 1);
  pll_seq_state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [KW-1:0] k, k_n;
  logic [RW-1:0] retry_n;
  logic [LOL_W-1:0] lol_n;
  logic [N_PLL-1:0] dom_n, synced, stable;
  logic ready_n, fault_n, fail, lost, all_stable;
  assign o_pll_rst = {N_PLL{state == PLL_RST || state == FAULT}};
  assign all_stable = &stable;
  assign lost = ~&synced;
  for (genvar g = 0; g < N_PLL; g++) begin : g_filt
    lock_filter #(.SYNC_STAGES(SYNC_STAGES), .LOCK_FILTER(LOCK_FILTER)) u_filt (
      .clk(i_clk), .rst(i_rst), .lock(i_lock[g]), .hold(o_pll_rst[g]),
      .synced(synced[g]), .stable(stable[g])
    );
  end
  // next state and next registered outputs; a failed attempt retries until the budget is spent
  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    k_n = k;
    retry_n = o_retry_cnt;
    lol_n = o_lol_cnt;
    dom_n = o_dom_rst;
    ready_n = o_ready;
    fault_n = o_fault;
    fail = 1'b0;
    case (state)
      PLL_RST:
        if (timer == TW'(PLL_RST_CYCLES - 1)) begin
          state_n = WAIT_LOCK;
          timer_n = '0;
        end
      WAIT_LOCK:
        if (all_stable) begin
          state_n = RELEASE;
          timer_n = '0;
          k_n = '0;
          dom_n[0] = 1'b0;
        end else fail = timer == TW'(LOCK_TIMEOUT - 1);
      RELEASE:
        if (lost) fail = 1'b1;
        else if (timer == TW'(RELEASE_GAP - 1)) begin
          timer_n = '0;
          if (k == KW'(N_PLL - 1)) begin
            state_n = RUN;
            ready_n = 1'b1;
            retry_n = '0;
          end else begin
            k_n = k + 1'b1;
            dom_n[k_n] = 1'b0;
          end
        end
      RUN: begin
        timer_n = '0;
        if (lost) begin
          state_n = PLL_RST;
          dom_n = '1;
          ready_n = 1'b0;
          lol_n = (&o_lol_cnt) ? o_lol_cnt : o_lol_cnt + 1'b1;
        end
      end
      default: timer_n = '0;
    endcase
    if (fail) begin
      dom_n = '1;
      timer_n = '0;
      state_n = (o_retry_cnt < RW'(MAX_RETRIES)) ? PLL_RST : FAULT;
      retry_n = (o_retry_cnt < RW'(MAX_RETRIES)) ? o_retry_cnt + 1'b1 : o_retry_cnt;
      fault_n = !(o_retry_cnt < RW'(MAX_RETRIES));
    end
  end
  // state, timer and all registered outputs
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= PLL_RST;
      timer <= '0;
      k <= '0;
      o_retry_cnt <= '0;
      o_lol_cnt <= '0;
      o_dom_rst <= '1;
      o_ready <= 1'b0;
      o_fault <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      k <= k_n;
      o_retry_cnt <= retry_n;
      o_lol_cnt <= lol_n;
      o_dom_rst <= dom_n;
      o_ready <= ready_n;
      o_fault <= fault_n;
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: history-window reference model plus directed scenarios for the sequencer
module tb_pll_reset_sequencer;
  localparam int LF = 4, TO = 100, PRC = 3, GAP = 5, MAXR = 2, HN = 32768;
  localparam int P_PRST = 0, P_WAIT = 1, P_REL = 2, P_RUN = 3, P_FLT = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] lock = 2'b00;
  logic [1:0] pll_rst, dom_rst, retry_cnt;
  logic ready, fault;
  logic [7:0] lol_cnt;
  int n_cmp = 0, n_bad = 0;

  pll_reset_sequencer #(
    .N_PLL(2), .SYNC_STAGES(2), .LOCK_FILTER(LF), .LOCK_TIMEOUT(TO),
    .PLL_RST_CYCLES(PRC), .RELEASE_GAP(GAP), .MAX_RETRIES(MAXR)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_lock(lock), .o_pll_rst(pll_rst), .o_dom_rst(dom_rst),
    .o_ready(ready), .o_fault(fault), .o_retry_cnt(retry_cnt), .o_lol_cnt(lol_cnt)
  );

  always #5 clk = ~clk;

  // reference model: lock history per edge, phase plus phase start edge
  bit [1:0] lk [HN];
  bit pr [HN];
  int cyc = 0, last_rst = 0, ph = P_PRST, st = 0, m_retry = 0, m_lol = 0;
  bit armed = 0, all_st, lost;
  logic [1:0] m_dom;
  logic m_prst, m_ready, m_fault;

  function automatic bit synced_after(input int e, input int c);
    return (e - 1 > last_rst) ? lk[e-1][c] : 1'b0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    all_st = 1'b1;
    lost = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (!synced_after(cyc - 1, c)) lost = 1'b1;
      for (int j = 1; j <= LF; j++)
        if (cyc - j <= last_rst || !synced_after(cyc - j - 1, c) || pr[cyc-j-1]) all_st = 1'b0;
    end
    if (rst) begin
      ph = P_PRST; st = cyc; m_retry = 0; m_lol = 0; last_rst = cyc; armed = 1'b1;
    end else if (ph == P_PRST) begin
      if (cyc - st == PRC) begin ph = P_WAIT; st = cyc; end
    end else if (ph == P_WAIT || ph == P_REL) begin
      if (ph == P_WAIT && all_st) begin ph = P_REL; st = cyc; end
      else if ((ph == P_WAIT && cyc - st == TO) || (ph == P_REL && lost)) begin
        if (m_retry < MAXR) begin m_retry++; ph = P_PRST; end
        else ph = P_FLT;
        st = cyc;
      end else if (ph == P_REL && cyc - st == 2 * GAP) begin
        ph = P_RUN; st = cyc; m_retry = 0;
      end
    end else if (ph == P_RUN && lost) begin
      ph = P_PRST; st = cyc; m_lol = (m_lol < 255) ? m_lol + 1 : 255;
    end
    m_prst = (ph == P_PRST || ph == P_FLT);
    m_ready = ph == P_RUN;
    m_fault = ph == P_FLT;
    for (int b = 0; b < 2; b++) m_dom[b] = (ph == P_REL) ? ((cyc - st) < b * GAP) : (ph != P_RUN);
    lk[cyc] = lock;
    pr[cyc] = m_prst;
  end

  // compare every cycle once the model has seen a reset
  always @(negedge clk)
    if (armed) begin
      n_cmp++;
      if (pll_rst !== {2{m_prst}} || dom_rst !== m_dom || ready !== m_ready || fault !== m_fault ||
          retry_cnt !== 2'(m_retry) || lol_cnt !== 8'(m_lol)) begin
        n_bad++;
        $display("FAIL model cyc=%0d: pll_rst=%b/%b dom=%b/%b ready=%b/%b fault=%b/%b retry=%0d/%0d lol=%0d/%0d (dut/model)",
                 cyc, pll_rst, {2{m_prst}}, dom_rst, m_dom, ready, m_ready, fault, m_fault,
                 retry_cnt, m_retry, lol_cnt, m_lol);
      end
    end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit cond(input int w);
    return w == 0 ? ready : w == 1 ? !dom_rst[0] : w == 2 ? fault : w == 3 ? (retry_cnt == 2'd2) : (pll_rst == 2'b00);
  endfunction

  task automatic wait_for(input string nm, input int w, input int budget);
    int n = 0;
    while (!cond(w) && n < budget) begin tick(1); n++; end
    if (!cond(w)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout after %0d cycles", nm, budget);
    end
  endtask

  task automatic drop_lock(input logic [1:0] v);
    lock = v;
    tick(1);
    lock = 2'b11;
  endtask

  initial begin
    int n;
    tick(3);
    rst = 1'b0;
    n = 0;
    while (pll_rst == 2'b11 && n < 20) begin n++; tick(1); end
    chk("prst_len", n, 3);
    lock = 2'b11;
    n = 0;
    while (dom_rst[0] && n < 50) begin tick(1); n++; end
    chk("dom0_lat", n, 7);
    n = 0;
    while (dom_rst[1] && n < 50) begin tick(1); n++; end
    chk("dom1_gap", n, 5);
    n = 0;
    while (!ready && n < 50) begin tick(1); n++; end
    chk("ready_gap", n, 5);
    chk("run_retry", retry_cnt, 0);
    chk("run_lol", lol_cnt, 0);

    drop_lock(2'b01);
    tick(2);
    chk("lol_dom", dom_rst, 3);
    chk("lol_ready", ready, 0);
    chk("lol_cnt1", lol_cnt, 1);
    n = 0;
    while (pll_rst == 2'b11 && n < 20) begin n++; tick(1); end
    chk("lol_prst_len", n, 3);
    wait_for("relock_ready", 0, 100);
    chk("relock_retry", retry_cnt, 0);

    drop_lock(2'b01);
    tick(2);
    wait_for("t5_dom0", 1, 100);
    drop_lock(2'b10);
    tick(2);
    chk("t5_dom", dom_rst, 3);
    chk("t5_retry", retry_cnt, 1);
    chk("t5_lol", lol_cnt, 2);
    wait_for("t5_ready", 0, 100);
    chk("t5_retry_clr", retry_cnt, 0);

    drop_lock(2'b01);
    tick(2);
    wait_for("t6_dom0", 1, 100);
    rst = 1'b1;
    tick(1);
    chk("rst_prst", pll_rst, 3);
    chk("rst_dom", dom_rst, 3);
    chk("rst_ready", ready, 0);
    chk("rst_lol", lol_cnt, 0);
    chk("rst_retry", retry_cnt, 0);
    rst = 1'b0;
    wait_for("t6_ready", 0, 100);

    for (int i = 0; i < 256; i++) begin
      drop_lock(2'b01);
      tick(3);
      wait_for("lol_loop_ready", 0, 100);
      if (i == 254) chk("lol_255", lol_cnt, 255);
    end
    chk("lol_sat", lol_cnt, 255);

    rst = 1'b1;
    lock = 2'b00;
    tick(2);
    rst = 1'b0;
    wait_for("t4_wait", 4, 20);
    chk("t4_retry0", retry_cnt, 0);
    n = 0;
    while (pll_rst == 2'b00 && n < 200) begin
      lock = {1'b1, (n % 3) != 2};
      n++;
      tick(1);
    end
    chk("t4_wait_len", n, 100);
    chk("t4_retry1", retry_cnt, 1);
    lock = 2'b00;
    wait_for("t2_retry2", 3, 300);
    wait_for("t2_fault", 2, 300);
    chk("t2_fault_prst", pll_rst, 3);
    chk("t2_fault_dom", dom_rst, 3);
    chk("t2_fault_retry", retry_cnt, 2);
    lock = 2'b11;
    tick(30);
    chk("t2_fault_sticky", fault, 1);
    chk("t2_ready_low", ready, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("fault_clr", fault, 0);
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
